// File: rtl/dds_pkg.sv
// dds_pkg: shared widths, sweep FSM states and the sweep configuration bundle
// used by dds_sweep_ctrl and its phase accumulator.
package dds_pkg;

  localparam int ACC_DW = 32;
  localparam int CNT_DW = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sweep_state_t;

  typedef struct packed {
    logic [ACC_DW-1:0] start_fcw;
    logic [ACC_DW-1:0] step_fcw;
    logic [ACC_DW-1:0] phase_offset;
    logic [CNT_DW-1:0] num_steps;
    logic [CNT_DW-1:0] dwell;
    logic              rpt;
  } sweep_cfg_t;

endpackage

// File: rtl/dds_phase_acc.sv
// dds_phase_acc: loadable phase accumulator, acc += fcw when enabled (mod 2^ACC_DW).
// Ports: clk_i, reset_i (sync, high), load_i/load_val_i, en_i/fcw_i, acc_o.
module dds_phase_acc #(
  parameter int ACC_DW = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic [ACC_DW-1:0] load_val_i,
  input  logic              en_i,
  input  logic [ACC_DW-1:0] fcw_i,
  output logic [ACC_DW-1:0] acc_o
);

  logic [ACC_DW-1:0] acc_q;
  logic [ACC_DW-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = load_val_i;
    end else if (en_i) begin
      acc_d = acc_q + fcw_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear-chirp scheduler feeding the dds phase stream.
// Ports: clk/reset, cfg_* config write (IDLE only), start/stop, m_axis_phase_*, busy, done.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int ACC_DW   = 32,
  parameter int PHASE_DW = 16,
  parameter int CNT_DW   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [ACC_DW-1:0]   cfg_start_fcw,
  input  logic [ACC_DW-1:0]   cfg_step_fcw,
  input  logic [ACC_DW-1:0]   cfg_phase_offset,
  input  logic [CNT_DW-1:0]   cfg_num_steps,
  input  logic [CNT_DW-1:0]   cfg_dwell,
  input  logic                cfg_repeat,
  input  logic                start,
  input  logic                stop,
  output logic [PHASE_DW-1:0] m_axis_phase_tdata,
  output logic                m_axis_phase_tvalid,
  input  logic                m_axis_phase_tready,
  output logic                busy,
  output logic                done
);

  sweep_state_t      state_q, state_d;
  sweep_cfg_t        cfg_q, cfg_d, cfg_in;
  logic [ACC_DW-1:0] fcw_q, fcw_d;
  logic [CNT_DW-1:0] step_q, step_d;
  logic [CNT_DW-1:0] dwell_q, dwell_d;
  logic              done_q, done_d;

  logic              acc_load;
  logic              acc_en;
  logic [ACC_DW-1:0] acc;

  logic              beat;
  logic [CNT_DW-1:0] ns_m1;
  logic [CNT_DW-1:0] dw_m1;
  logic              dwell_end;
  logic              sweep_end;

  always_comb begin
    cfg_in              = '0;
    cfg_in.start_fcw    = cfg_start_fcw;
    cfg_in.step_fcw     = cfg_step_fcw;
    cfg_in.phase_offset = cfg_phase_offset;
    cfg_in.num_steps    = cfg_num_steps;
    cfg_in.dwell        = cfg_dwell;
    cfg_in.rpt          = cfg_repeat;
  end

  // Zero counts behave as one; compare against (count-1).
  assign ns_m1 = (cfg_q.num_steps == '0) ? '0
               : cfg_q.num_steps - 1'b1;
  assign dw_m1 = (cfg_q.dwell == '0) ? '0
               : cfg_q.dwell - 1'b1;

  assign beat      = (state_q == RUN) & m_axis_phase_tready;
  assign dwell_end = (dwell_q == dw_m1);
  assign sweep_end = dwell_end & (step_q == ns_m1);

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    fcw_d    = fcw_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    done_d   = 1'b0;
    acc_load = 1'b0;
    acc_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          cfg_d = cfg_in;
        end
        if (start) begin
          state_d  = RUN;
          acc_load = 1'b1;
          fcw_d    = cfg_d.start_fcw;
          step_d   = '0;
          dwell_d  = '0;
        end
      end
      RUN: begin
        acc_en = beat;
        if (beat) begin
          dwell_d = dwell_q + 1'b1;
          if (dwell_end) begin
            dwell_d = '0;
            fcw_d   = fcw_q + cfg_q.step_fcw;
            step_d  = step_q + 1'b1;
            if (sweep_end) begin
              if (cfg_q.rpt) begin
                // Phase-continuous restart: acc keeps running.
                fcw_d  = cfg_q.start_fcw;
                step_d = '0;
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
        if (stop) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      fcw_q   <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      fcw_q   <= fcw_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      done_q  <= done_d;
    end
  end

  dds_phase_acc #(
    .ACC_DW(ACC_DW)
  ) u_acc (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (acc_load),
    .load_val_i (cfg_d.phase_offset),
    .en_i       (acc_en),
    .fcw_i      (fcw_q),
    .acc_o      (acc)
  );

  // Only the top PHASE_DW bits leave the block.
  logic unused_acc;
  assign unused_acc = &{1'b0, acc};

  assign m_axis_phase_tdata  = acc[ACC_DW-1 -: PHASE_DW];
  assign m_axis_phase_tvalid = (state_q == RUN);
  assign busy                = (state_q == RUN);
  assign cfg_ready           = (state_q == IDLE);
  assign done                = done_q;

endmodule
